// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and state encoding for the four-way round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int unsigned NR_REQ  = 4;
  localparam int unsigned SEL_LEN = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/MuxKey.sv
// Library key/value mux: lut packs NR_KEY {key, data} pairs, the pair whose key matches drives out.
module MuxKey #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic [KEY_LEN-1:0]                 key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [DATA_LEN-1:0]                out
);

  localparam int unsigned PAIR_LEN = KEY_LEN + DATA_LEN;

  // No match yields zero rather than a latch.
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_LEN +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requesters: rotate by ptr, fixed-priority encode, rotate back.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NR_REQ-1:0]  req_valid,
  input  logic [SEL_LEN-1:0] ptr,
  output logic               hit,
  output logic [SEL_LEN-1:0] g
);

  logic [2*NR_REQ-1:0] dbl;
  logic [NR_REQ-1:0]   rot;
  logic [SEL_LEN-1:0]  off;

  always_comb begin
    dbl = {req_valid, req_valid};
    rot = dbl[ptr +: NR_REQ];
    // Scan high to low so the lowest set offset from ptr wins.
    off = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_LEN'(i);
    end
    hit = |req_valid;
    g   = off + ptr;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter feeding one registered output slot with valid/ready handshake.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_REQ-1:0]          req_valid,
  input  logic [NR_REQ*DATA_LEN-1:0] req_data,
  output logic [NR_REQ-1:0]          req_ready,
  output logic                       out_valid,
  output logic [DATA_LEN-1:0]        out_data,
  output logic [SEL_LEN-1:0]         out_sel,
  input  logic                       out_ready
);

  localparam int unsigned PAIR_LEN = SEL_LEN + DATA_LEN;

  state_e                     state, state_nxt;
  logic [SEL_LEN-1:0]         ptr, g;
  logic                       hit, can_load, load;
  logic [DATA_LEN-1:0]        mux_data;
  logic [NR_REQ*PAIR_LEN-1:0] lut;

  rr_pick4 u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .hit       (hit),
    .g         (g)
  );

  // Pair each requester's word with its index for the keyed mux.
  always_comb begin
    lut = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      lut[i*PAIR_LEN +: PAIR_LEN] = {SEL_LEN'(i), req_data[i*DATA_LEN +: DATA_LEN]};
    end
  end

  MuxKey #(
    .NR_KEY   (NR_REQ),
    .KEY_LEN  (SEL_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_mux (
    .key (g),
    .lut (lut),
    .out (mux_data)
  );

  // Next state and accept strobe; load while draining keeps the slot full.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    can_load  = (state == EMPTY) | out_ready;
    load      = can_load & hit;
    if (load) begin
      req_ready = NR_REQ'(1) << g;
      state_nxt = FULL;
    end else if ((state == FULL) && out_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Slot payload and pointer move only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= '0;
    end else if (load) begin
      out_data <= mux_data;
      out_sel  <= g;
      ptr      <= g + SEL_LEN'(1);
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a round-robin model predicts grants and queues expected output words.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [9:0] sb[$];
  logic [1:0] m_ptr = '0;
  logic       m_full = 1'b0;
  logic       m_load = 1'b0;
  logic [1:0] m_g = '0;
  logic [9:0] exp_w;
  logic [3:0] exp_rr;

  mux_rr_arbiter #(.DATA_LEN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Reference grant for the current inputs; queues the word that should appear next cycle.
  function automatic logic [3:0] model_rr();
    logic [1:0] idx;
    m_load = 1'b0;
    m_g    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = 2'(m_ptr + 2'(k));
      if (!m_load && req_valid[idx] && (!m_full || out_ready)) begin
        m_load = 1'b1;
        m_g    = idx;
      end
    end
    if (m_load) sb.push_back({m_g, req_data[m_g*8 +: 8]});
    return m_load ? (4'b0001 << m_g) : 4'b0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (m_load) begin
      m_full = 1'b1;
      m_ptr  = m_g + 2'd1;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_ptr  = '0;
    m_full = 1'b0;
    m_load = 1'b0;
    sb.delete();
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", out_data); end
    checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d want=0", out_sel); end
    for (int c = 0; c < 10; c++) begin
      req_valid = '0;
      out_ready = 1'(c % 2);
      #2;
      exp_rr = model_rr();
      checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL idle_ready c=%0d got=%b want=%b", c, req_ready, exp_rr); end
      checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL idle_out c=%0d got=%b/%h want=0/00", c, out_valid, out_data); end
      tick();
    end
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_data  = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
    out_ready = 1'b1;
    #2;
    exp_rr = model_rr();
    checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL single_ready got=%b want=%b", req_ready, exp_rr); end
    tick();
    if (m_load) begin
      exp_w = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL single_out got=%b/%0d/%h want=1/%0d/%h", out_valid, out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
    end
  endtask

  task automatic test_wrap_skip();
    req_valid = 4'b0011;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      exp_rr = model_rr();
      checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL wrap_ready c=%0d got=%b want=%b", c, req_ready, exp_rr); end
      tick();
      if (m_load) begin
        exp_w = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL wrap_out c=%0d got=%0d/%h want=%0d/%h", c, out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
      end
    end
    req_valid = '0;
    #2;
    exp_rr = model_rr();
    tick();
    checks++; if (out_valid !== 1'b0 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL drain_hold got=%b/%0d/%h want=0/%0d/%h", out_valid, out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
  endtask

  task automatic test_fairness();
    apply_reset();
    req_valid = 4'b1111;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #2;
      exp_rr = model_rr();
      checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL fair_ready c=%0d got=%b want=%b", c, req_ready, exp_rr); end
      tick();
      if (!m_load || sb.size() == 0) begin
        errors++; checks++; $display("FAIL fair_nogrant c=%0d got=0 want=1", c);
      end else begin
        exp_w = sb.pop_front();
        checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w || out_sel !== 2'(c % 4)) begin errors++; $display("FAIL fair_out c=%0d got=%b/%0d/%h want=1/%0d/%h", c, out_valid, out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 4'b1111;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #2;
    exp_rr = model_rr();
    checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL bp_first_ready got=%b want=%b", req_ready, exp_rr); end
    tick();
    if (m_load) exp_w = sb.pop_front();
    checks++; if ({out_sel, out_data} !== 10'h010 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL bp_first_out got=%0d/%h want=0/10", out_sel, out_data); end
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      exp_rr = model_rr();
      checks++; if (req_ready !== exp_rr || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c=%0d got=%b want=0000", c, req_ready); end
      checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL bp_hold c=%0d got=%b/%0d/%h want=1/%0d/%h", c, out_valid, out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
      tick();
    end
    out_ready = 1'b1;
    #2;
    exp_rr = model_rr();
    checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL bp_release_ready got=%b want=%b", req_ready, exp_rr); end
    tick();
    if (m_load) begin
      exp_w = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL bp_release_out got=%0d/%h want=%0d/%h", out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid = 4'b0010;
    req_data  = {8'h9D, 8'h77, 8'h66, 8'h55};
    out_ready = 1'b0;
    #2;
    exp_rr = model_rr();
    tick();
    if (m_load) exp_w = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL ar_pre got=%b/%0d/%h want=1/%0d/%h", out_valid, out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin errors++; $display("FAIL ar_immediate got=%b/%0d/%h want=0/0/00", out_valid, out_sel, out_data); end
    @(posedge clk);
    #1;
    m_ptr  = '0;
    m_full = 1'b0;
    m_load = 1'b0;
    sb.delete();
    rst_n     = 1'b1;
    req_valid = 4'b1000;
    out_ready = 1'b1;
    #2;
    exp_rr = model_rr();
    checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL ar_after_ready got=%b want=%b", req_ready, exp_rr); end
    tick();
    if (m_load) begin
      exp_w = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || {out_sel, out_data} !== exp_w) begin errors++; $display("FAIL ar_after_out got=%0d/%h want=%0d/%h", out_sel, out_data, exp_w[9:8], exp_w[7:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_skip();
    test_fairness();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
